// File: rtl/axi_pkg.sv
// Shared AXI4 encodings and the data-memory bridge state type.
package axi_pkg;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [2:0] AXI_SIZE_4B    = 3'b010;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_DATA,
        WR_REQ,
        WR_RESP,
        DONE
    } dm_state_e;

endpackage

// File: rtl/cpu_dm_axi_master.sv
// CPU data-memory port to single-beat AXI4 master bridge.
// Holds the pipeline stalled until each request's response returns.
module cpu_dm_axi_master
    import axi_pkg::*;
#(
    parameter int              ID_W      = 4,
    parameter logic [ID_W-1:0] MASTER_ID = 4'd1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            dm_ceb,
    input  logic            dm_web,
    input  logic [3:0]      dm_bweb,
    input  logic [31:0]     dm_a,
    input  logic [31:0]     dm_in,
    output logic [31:0]     dm_out,
    output logic            dm_stall,
    output logic            bus_err,
    output logic [ID_W-1:0] arid,
    output logic [31:0]     araddr,
    output logic [3:0]      arlen,
    output logic [2:0]      arsize,
    output logic [1:0]      arburst,
    output logic            arvalid,
    input  logic            arready,
    input  logic [ID_W-1:0] rid,
    input  logic [31:0]     rdata,
    input  logic [1:0]      rresp,
    input  logic            rlast,
    input  logic            rvalid,
    output logic            rready,
    output logic [ID_W-1:0] awid,
    output logic [31:0]     awaddr,
    output logic [3:0]      awlen,
    output logic [2:0]      awsize,
    output logic [1:0]      awburst,
    output logic            awvalid,
    input  logic            awready,
    output logic [31:0]     wdata,
    output logic [3:0]      wstrb,
    output logic            wlast,
    output logic            wvalid,
    input  logic            wready,
    input  logic [ID_W-1:0] bid,
    input  logic [1:0]      bresp,
    input  logic            bvalid,
    output logic            bready
);

    dm_state_e   state, state_n;
    logic        aw_done, w_done;
    logic [31:0] addr_q, wdata_q;
    logic [3:0]  wstrb_q;
    logic        stall_c;
    logic        unused_ok;

    assign unused_ok = ^{rid, rlast, bid, rresp[0], bresp[0]};

    assign arid    = MASTER_ID;
    assign awid    = MASTER_ID;
    assign arlen   = 4'd0;
    assign awlen   = 4'd0;
    assign arsize  = AXI_SIZE_4B;
    assign awsize  = AXI_SIZE_4B;
    assign arburst = AXI_BURST_INCR;
    assign awburst = AXI_BURST_INCR;
    assign araddr  = addr_q;
    assign awaddr  = addr_q;
    assign wdata   = wdata_q;
    assign wstrb   = wstrb_q;
    assign wlast   = wvalid;

    // Stall is released while reset is held so the core sees no hang.
    assign dm_stall = stall_c & rst;

    always_comb begin
        state_n = state;
        stall_c = 1'b0;
        arvalid = 1'b0;
        rready  = 1'b0;
        awvalid = 1'b0;
        wvalid  = 1'b0;
        bready  = 1'b0;
        unique case (state)
            IDLE: begin
                if (!dm_ceb) begin
                    stall_c = 1'b1;
                    state_n = dm_web ? RD_ADDR : WR_REQ;
                end
            end
            RD_ADDR: begin
                stall_c = 1'b1;
                arvalid = 1'b1;
                if (arready) state_n = RD_DATA;
            end
            RD_DATA: begin
                stall_c = 1'b1;
                rready  = 1'b1;
                if (rvalid) state_n = DONE;
            end
            WR_REQ: begin
                stall_c = 1'b1;
                awvalid = !aw_done;
                wvalid  = !w_done;
                if ((aw_done || awready) && (w_done || wready))
                    state_n = WR_RESP;
            end
            WR_RESP: begin
                stall_c = 1'b1;
                bready  = 1'b1;
                if (bvalid) state_n = DONE;
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            dm_out  <= '0;
            bus_err <= 1'b0;
        end else begin
            state   <= state_n;
            bus_err <= 1'b0;
            if (state == IDLE && !dm_ceb) begin
                addr_q  <= dm_a;
                wdata_q <= dm_in;
                wstrb_q <= ~dm_bweb;
            end
            if (state == WR_REQ) begin
                if (state_n == WR_RESP) begin
                    aw_done <= 1'b0;
                    w_done  <= 1'b0;
                end else begin
                    if (awvalid && awready) aw_done <= 1'b1;
                    if (wvalid && wready)   w_done  <= 1'b1;
                end
            end
            if (state == RD_DATA && rvalid) begin
                dm_out  <= rdata;
                bus_err <= rresp[1];
            end
            if (state == WR_RESP && bvalid)
                bus_err <= bresp[1];
        end
    end

endmodule
